// File: rtl/intersection_light_ctrl.sv
// intersection_light_ctrl
//   Two-road (NS / EW) intersection controller. The day cycle is
//   NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G. A latched pedestrian
//   request caps the remaining NS green and grants a walk lamp during EW green.
//   Night mode flashes both yellows. A 2-digit multiplexed 7-seg display shows
//   the seconds left in the current phase.
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   night_mode       : level request for night flashing (sampled at phase end)
//   ped_req          : one-cycle pedestrian button pulse
//   led_ns, led_ew   : {r,y,g} lamps, active-high, registered
//   ped_walk         : walk lamp for crossing the NS road
//   seg_out          : {dp,g,f,e,d,c,b,a}, active-low
//   seg_sel          : active-low digit enables, [0] ones, [1] tens
module intersection_light_ctrl #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int NS_GREEN_TIME  = 30,
  parameter int EW_GREEN_TIME  = 20,
  parameter int YELLOW_TIME    = 4,
  parameter int ALLRED_TIME    = 2,
  parameter int PED_SHORT_TIME = 5,
  parameter int SCAN_DIV       = 2**17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       night_mode,
  input  logic       ped_req,
  output logic [2:0] led_ns,
  output logic [2:0] led_ew,
  output logic       ped_walk,
  output logic [7:0] seg_out,
  output logic [1:0] seg_sel
);

  if (NS_GREEN_TIME < 1 || NS_GREEN_TIME > 99 || EW_GREEN_TIME < 1 || EW_GREEN_TIME > 99 ||
      YELLOW_TIME < 1 || YELLOW_TIME > 99 || ALLRED_TIME < 1 || ALLRED_TIME > 99 ||
      PED_SHORT_TIME < 1 || PED_SHORT_TIME > 99) begin : g_bad_time
    $error("intersection_light_ctrl: every *_TIME parameter must be in 1..99");
  end
  if (CLK_FREQ < 4 || (CLK_FREQ % 2) != 0 || SCAN_DIV < 1) begin : g_bad_clk
    $error("intersection_light_ctrl: CLK_FREQ must be even and >= 4, SCAN_DIV >= 1");
  end

  localparam int SEC_W  = $clog2(CLK_FREQ);
  localparam int HALF   = CLK_FREQ / 2;
  localparam int BLK_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SCAN_W = $clog2(2 * SCAN_DIV);

  localparam logic [SEC_W-1:0]  SEC_LAST   = SEC_W'(CLK_FREQ - 1);
  localparam logic [BLK_W-1:0]  BLINK_LAST = BLK_W'(HALF - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(2 * SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_HALF  = SCAN_W'(SCAN_DIV);
  localparam logic [6:0]        T_PED      = 7'(PED_SHORT_TIME);

  typedef enum logic [2:0] {S_NS_G, S_NS_Y, S_AR1, S_EW_G, S_EW_Y, S_AR2, S_NIGHT} state_t;

  state_t             state_q, state_d;
  logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic [6:0]         time_cnt_q, time_cnt_d;
  logic               ped_pending_q, ped_pending_d;
  logic               ped_walk_q, ped_walk_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]         led_ns_q, led_ns_d, led_ew_q, led_ew_d;

  logic       sec_tick, phase_end, state_chg;
  logic [3:0] tens_dig, ones_dig;

  assign sec_tick  = (sec_cnt_q == SEC_LAST);
  assign phase_end = sec_tick && (time_cnt_q == 7'd1);
  assign state_chg = (state_d != state_q);

  function automatic logic [6:0] dur(input state_t s);
    case (s)
      S_NS_G:        dur = 7'(NS_GREEN_TIME);
      S_EW_G:        dur = 7'(EW_GREEN_TIME);
      S_NS_Y, S_EW_Y: dur = 7'(YELLOW_TIME);
      S_AR1, S_AR2:  dur = 7'(ALLRED_TIME);
      default:       dur = 7'd0;
    endcase
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'hC0;
      4'd1: seg7 = 8'hF9;
      4'd2: seg7 = 8'hA4;
      4'd3: seg7 = 8'hB0;
      4'd4: seg7 = 8'h99;
      4'd5: seg7 = 8'h92;
      4'd6: seg7 = 8'h82;
      4'd7: seg7 = 8'hF8;
      4'd8: seg7 = 8'h80;
      4'd9: seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // state register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_NS_G;
      sec_cnt_q     <= '0;
      time_cnt_q    <= 7'(NS_GREEN_TIME);
      ped_pending_q <= 1'b0;
      ped_walk_q    <= 1'b0;
      blink_cnt_q   <= '0;
      blink_q       <= 1'b1;
      scan_cnt_q    <= '0;
      led_ns_q      <= 3'b001;
      led_ew_q      <= 3'b100;
    end else begin
      state_q       <= state_d;
      sec_cnt_q     <= sec_cnt_d;
      time_cnt_q    <= time_cnt_d;
      ped_pending_q <= ped_pending_d;
      ped_walk_q    <= ped_walk_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_q       <= blink_d;
      scan_cnt_q    <= scan_cnt_d;
      led_ns_q      <= led_ns_d;
      led_ew_q      <= led_ew_d;
    end
  end

  // next state: night_mode only matters at a phase-end tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NS_G:  if (phase_end) state_d = night_mode ? S_NIGHT : S_NS_Y;
      S_NS_Y:  if (phase_end) state_d = night_mode ? S_NIGHT : S_AR1;
      S_AR1:   if (phase_end) state_d = night_mode ? S_NIGHT : S_EW_G;
      S_EW_G:  if (phase_end) state_d = night_mode ? S_NIGHT : S_EW_Y;
      S_EW_Y:  if (phase_end) state_d = night_mode ? S_NIGHT : S_AR2;
      S_AR2:   if (phase_end) state_d = night_mode ? S_NIGHT : S_NS_G;
      S_NIGHT: if (sec_tick && !night_mode) state_d = S_AR2;
      default: state_d = S_NS_G;
    endcase
  end

  // counters and pedestrian bookkeeping
  always_comb begin
    sec_cnt_d  = sec_tick ? '0 : sec_cnt_q + SEC_W'(1);
    scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + SCAN_W'(1);

    time_cnt_d = time_cnt_q;
    if (state_chg)
      time_cnt_d = dur(state_d);
    else if (state_q == S_NIGHT)
      time_cnt_d = 7'd0;
    else if (sec_tick && time_cnt_q > 7'd1)
      time_cnt_d = time_cnt_q - 7'd1;
    // cap only on non-tick cycles so a coinciding decrement is not lost
    else if (state_q == S_NS_G && ped_pending_q && time_cnt_q > T_PED)
      time_cnt_d = T_PED;

    // NIGHT entry clears; otherwise a new request beats the EW_G-entry clear
    ped_pending_d = ped_pending_q;
    if (state_chg && state_d == S_NIGHT)
      ped_pending_d = 1'b0;
    else if (ped_req && state_q != S_NIGHT)
      ped_pending_d = 1'b1;
    else if (state_chg && state_d == S_EW_G)
      ped_pending_d = 1'b0;

    ped_walk_d = ped_walk_q;
    if (state_chg && state_d == S_EW_G)
      ped_walk_d = ped_pending_q;
    else if (state_chg && state_q == S_EW_G)
      ped_walk_d = 1'b0;

    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (state_chg && state_d == S_NIGHT) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (state_q == S_NIGHT) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  assign tens_dig = 4'(time_cnt_q / 7'd10);
  assign ones_dig = 4'(time_cnt_q % 7'd10);

  // outputs: lamp next-values (registered) and display mux
  always_comb begin
    led_ns_d = 3'b100;
    led_ew_d = 3'b100;
    case (state_q)
      S_NS_G:  led_ns_d = 3'b001;
      S_NS_Y:  led_ns_d = 3'b010;
      S_EW_G:  led_ew_d = 3'b001;
      S_EW_Y:  led_ew_d = 3'b010;
      S_NIGHT: begin
        led_ns_d = {1'b0, blink_q, 1'b0};
        led_ew_d = {1'b0, blink_q, 1'b0};
      end
      default: ;
    endcase

    if (state_q == S_NIGHT) begin
      seg_sel = 2'b11;
      seg_out = 8'hFF;
    end else if (scan_cnt_q < SCAN_HALF) begin
      seg_sel = 2'b10;
      seg_out = seg7(ones_dig);
    end else begin
      seg_sel = 2'b01;
      seg_out = (tens_dig == 4'd0) ? 8'hFF : seg7(tens_dig);
    end
  end

  assign led_ns   = led_ns_q;
  assign led_ew   = led_ew_q;
  assign ped_walk = ped_walk_q;

endmodule

// File: tb/tb_intersection_light_ctrl.sv
// Self-checking bench for intersection_light_ctrl. A behavioural model steps
// once per clock from the phase rules; a second instance with a 12 s NS green
// exercises the tens digit against a closed-form countdown.
module tb_intersection_light_ctrl;
  localparam int CF = 10, SD = 2, NSG = 6, EWG = 4, YT = 2, ART = 1, PST = 2;
  localparam logic [16:0] RST_OUT = {3'b001, 3'b100, 1'b0, 2'b10, 8'h82};

  logic       clk, rst_n, night_mode, ped_req;
  logic [2:0] led_ns, led_ew;
  logic       ped_walk;
  logic [7:0] seg_out;
  logic [1:0] seg_sel;
  logic       night_mode2, ped_req2;
  logic [2:0] led_ns2, led_ew2;
  logic       ped_walk2;
  logic [7:0] seg_out2;
  logic [1:0] seg_sel2;

  int checks, errors;
  // model: phase 0..5 = NS_G,NS_Y,AR1,EW_G,EW_Y,AR2; 6 = NIGHT
  int m_sc, m_ph, m_rem, m_blk, m_scan, k2;
  bit m_pend, m_walk;
  logic [2:0] m_lns, m_lew;
  int dur [6];
  logic [7:0] segc [10];

  intersection_light_ctrl #(.CLK_FREQ(CF), .NS_GREEN_TIME(NSG), .EW_GREEN_TIME(EWG),
    .YELLOW_TIME(YT), .ALLRED_TIME(ART), .PED_SHORT_TIME(PST), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .night_mode(night_mode), .ped_req(ped_req),
    .led_ns(led_ns), .led_ew(led_ew), .ped_walk(ped_walk), .seg_out(seg_out), .seg_sel(seg_sel));

  intersection_light_ctrl #(.CLK_FREQ(CF), .NS_GREEN_TIME(12), .EW_GREEN_TIME(EWG),
    .YELLOW_TIME(YT), .ALLRED_TIME(ART), .PED_SHORT_TIME(PST), .SCAN_DIV(SD)) dut2 (
    .clk(clk), .rst_n(rst_n), .night_mode(night_mode2), .ped_req(ped_req2),
    .led_ns(led_ns2), .led_ew(led_ew2), .ped_walk(ped_walk2), .seg_out(seg_out2), .seg_sel(seg_sel2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [16:0] dut_out();
    return {led_ns, led_ew, ped_walk, seg_sel, seg_out};
  endfunction

  function automatic logic [16:0] exp_out();
    logic [1:0] sel;
    logic [7:0] so;
    if (m_ph == 6) begin
      sel = 2'b11; so = 8'hFF;
    end else if (m_scan < SD) begin
      sel = 2'b10; so = segc[m_rem % 10];
    end else begin
      sel = 2'b01; so = (m_rem / 10 == 0) ? 8'hFF : segc[m_rem / 10];
    end
    return {m_lns, m_lew, m_walk, sel, so};
  endfunction

  task automatic model_reset();
    m_sc = 0; m_ph = 0; m_rem = NSG; m_blk = 0; m_scan = 0; k2 = 0;
    m_pend = 0; m_walk = 0; m_lns = 3'b001; m_lew = 3'b100;
  endtask

  task automatic model_step(input bit ped, input bit night);
    bit tick, blink, old_pend;
    int np;
    tick     = (m_sc == CF - 1);
    blink    = ((m_blk / (CF / 2)) % 2) == 0;
    old_pend = m_pend;
    case (m_ph)
      0: begin m_lns = 3'b001; m_lew = 3'b100; end
      1: begin m_lns = 3'b010; m_lew = 3'b100; end
      3: begin m_lns = 3'b100; m_lew = 3'b001; end
      4: begin m_lns = 3'b100; m_lew = 3'b010; end
      6: begin m_lns = {1'b0, blink, 1'b0}; m_lew = {1'b0, blink, 1'b0}; end
      default: begin m_lns = 3'b100; m_lew = 3'b100; end
    endcase
    np = m_ph;
    if (m_ph == 6) begin
      if (tick && !night) np = 5;
    end else if (tick && m_rem == 1) begin
      np = night ? 6 : (m_ph + 1) % 6;
    end
    if (np != m_ph) begin
      if (np == 3) m_walk = old_pend;
      else if (m_ph == 3) m_walk = 0;
      if (np == 6) m_pend = 0;
      else if (ped && m_ph != 6) m_pend = 1;
      else if (np == 3) m_pend = 0;
      m_rem = (np == 6) ? 0 : dur[np];
      m_blk = 0;
    end else begin
      if (ped && m_ph != 6) m_pend = 1;
      if (m_ph == 6) m_blk++;
      else if (tick) m_rem--;
      else if (m_ph == 0 && old_pend && m_rem > PST) m_rem = PST;
    end
    m_ph   = np;
    m_sc   = (m_sc + 1) % CF;
    m_scan = (m_scan + 1) % (2 * SD);
  endtask

  task automatic run_cycle(input bit ped, input bit night);
    ped_req = ped; night_mode = night;
    @(posedge clk);
    model_step(ped, night);
    k2++;
    #1;
  endtask

  task automatic do_reset();
    ped_req = 0; night_mode = 0;
    @(negedge clk);
    rst_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset();
    #12;
    checks++;
    if (dut_out() !== RST_OUT) begin errors++; $display("FAIL reset_out got=%h want=%h", dut_out(), RST_OUT); end
    checks++;
    if (dut.time_cnt_q !== 7'd6 || dut.ped_pending_q !== 1'b0) begin
      errors++; $display("FAIL reset_regs time=%0d pend=%b want 6/0", dut.time_cnt_q, dut.ped_pending_q);
    end
    checks++;
    if ({led_ns2, led_ew2, ped_walk2, seg_sel2, seg_out2} !== {3'b001, 3'b100, 1'b0, 2'b10, 8'hA4}) begin
      errors++; $display("FAIL reset_dut2 got=%h", {led_ns2, led_ew2, ped_walk2, seg_sel2, seg_out2});
    end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      run_cycle(0, 0);
      checks++;
      if (dut_out() !== exp_out()) begin errors++; $display("FAIL start k=%0d got=%h want=%h", k2, dut_out(), exp_out()); end
      if (i == 8 || i == 9) begin
        checks++;
        if (dut.time_cnt_q !== ((i == 8) ? 7'd6 : 7'd5)) begin
          errors++; $display("FAIL first_tick k=%0d time=%0d", k2, dut.time_cnt_q);
        end
      end
    end
  endtask

  task automatic test_normal_cycle();
    int ew_green, ns_yel;
    ew_green = 0; ns_yel = 0;
    do_reset();
    for (int i = 0; i < 170; i++) begin
      run_cycle(0, 0);
      checks++;
      if (dut_out() !== exp_out()) begin errors++; $display("FAIL normal k=%0d got=%h want=%h", k2, dut_out(), exp_out()); end
      checks++;
      if (dut.time_cnt_q !== 7'(m_rem)) begin errors++; $display("FAIL normal_time k=%0d got=%0d want=%0d", k2, dut.time_cnt_q, m_rem); end
      checks++;
      if (!led_ns[2] && !led_ew[2]) begin errors++; $display("FAIL conflict k=%0d ns=%b ew=%b", k2, led_ns, led_ew); end
      if (led_ew == 3'b001) ew_green++;
      if (led_ns == 3'b010) ns_yel++;
    end
    checks++;
    if (ew_green != 40 || ns_yel != 20) begin
      errors++; $display("FAIL phase_len ew_g=%0d ns_y=%0d want 40/20", ew_green, ns_yel);
    end
  endtask

  task automatic test_ped_short();
    int walk_cyc;
    walk_cyc = 0;
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      run_cycle(k == 5, 0);
      checks++;
      if (dut_out() !== exp_out()) begin errors++; $display("FAIL ped k=%0d got=%h want=%h", k2, dut_out(), exp_out()); end
      checks++;
      if (dut.time_cnt_q !== 7'(m_rem) || dut.ped_pending_q !== m_pend) begin
        errors++; $display("FAIL ped_regs k=%0d time=%0d pend=%b want %0d/%b", k2, dut.time_cnt_q, dut.ped_pending_q, m_rem, m_pend);
      end
      if (k == 6) begin
        checks++;
        if (dut.time_cnt_q !== 7'd2) begin errors++; $display("FAIL ped_cap time=%0d want 2", dut.time_cnt_q); end
      end
      if (ped_walk) walk_cyc++;
    end
    checks++;
    if (walk_cyc != 40 || dut.ped_pending_q !== 1'b0) begin
      errors++; $display("FAIL ped_walk_len got=%0d pend=%b want 40/0", walk_cyc, dut.ped_pending_q);
    end
  endtask

  task automatic test_ped_at_ew_entry();
    int walk_early, walk_late;
    bit sent, p;
    walk_early = 0; walk_late = 0; sent = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      p = !sent && m_ph == 2 && m_sc == CF - 1 && m_rem == 1;
      if (p) sent = 1;
      run_cycle(p, 0);
      checks++;
      if (dut_out() !== exp_out()) begin errors++; $display("FAIL ew_entry k=%0d got=%h want=%h", k2, dut_out(), exp_out()); end
      if (ped_walk) begin
        if (k2 < 200) walk_early++; else walk_late++;
      end
    end
    checks++;
    if (walk_early != 0 || walk_late != 40) begin
      errors++; $display("FAIL ew_entry_walk first=%0d second=%0d want 0/40", walk_early, walk_late);
    end
  endtask

  task automatic test_night();
    int n, yel, allred;
    yel = 0; allred = 0; n = 0;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      run_cycle(0, 0);
      checks++;
      if (dut_out() !== exp_out()) begin errors++; $display("FAIL pre_night k=%0d got=%h want=%h", k2, dut_out(), exp_out()); end
    end
    while (m_ph != 6 && n < 100) begin
      run_cycle(0, 1); n++;
      checks++;
      if (dut_out() !== exp_out()) begin errors++; $display("FAIL night_wait k=%0d got=%h want=%h", k2, dut_out(), exp_out()); end
    end
    checks++;
    if (seg_sel !== 2'b11 || dut.time_cnt_q !== 7'd0 || k2 != 60) begin
      errors++; $display("FAIL night_entry k=%0d sel=%b time=%0d want k=60 sel=11 time=0", k2, seg_sel, dut.time_cnt_q);
    end
    for (int i = 0; i < 30; i++) begin
      run_cycle(0, 1);
      checks++;
      if (dut_out() !== exp_out()) begin errors++; $display("FAIL night k=%0d got=%h want=%h", k2, dut_out(), exp_out()); end
      if (led_ns == 3'b010 && led_ew == 3'b010) yel++;
    end
    checks++;
    if (yel != 15) begin errors++; $display("FAIL night_blink yellow_cycles=%0d want 15", yel); end
    for (int i = 0; i < 30; i++) begin
      run_cycle(0, 0);
      checks++;
      if (dut_out() !== exp_out()) begin errors++; $display("FAIL night_exit k=%0d got=%h want=%h", k2, dut_out(), exp_out()); end
      if (led_ns == 3'b100 && led_ew == 3'b100) allred++;
    end
    checks++;
    if (allred != 10) begin errors++; $display("FAIL night_ar2 allred_cycles=%0d want 10", allred); end
  endtask

  task automatic test_display();
    int r;
    logic [1:0] es;
    logic [7:0] eo;
    do_reset();
    for (int i = 0; i < 119; i++) begin
      run_cycle(0, 0);
      r = 12 - k2 / 10;
      if ((k2 % (2 * SD)) < SD) begin
        es = 2'b10; eo = segc[r % 10];
      end else begin
        es = 2'b01; eo = (r / 10 == 0) ? 8'hFF : segc[r / 10];
      end
      checks++;
      if ({seg_sel2, seg_out2} !== {es, eo}) begin
        errors++; $display("FAIL display k=%0d got=%b/%h want=%b/%h", k2, seg_sel2, seg_out2, es, eo);
      end
      checks++;
      if (dut_out() !== exp_out()) begin errors++; $display("FAIL display_dut1 k=%0d got=%h want=%h", k2, dut_out(), exp_out()); end
    end
  endtask

  task automatic test_random();
    bit p, nm;
    nm = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      p = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) nm = !nm;
      run_cycle(p, nm);
      checks++;
      if (dut_out() !== exp_out()) begin errors++; $display("FAIL random k=%0d got=%h want=%h", k2, dut_out(), exp_out()); end
      checks++;
      if (dut.time_cnt_q !== 7'(m_rem) || dut.ped_pending_q !== m_pend) begin
        errors++; $display("FAIL random_regs k=%0d time=%0d pend=%b want %0d/%b", k2, dut.time_cnt_q, dut.ped_pending_q, m_rem, m_pend);
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    bit sent, p;
    n = 0; sent = 0;
    do_reset();
    while (m_ph != 4 && n < 400) begin
      p = (m_ph == 3 && !sent);
      if (p) sent = 1;
      run_cycle(p, 0); n++;
    end
    ped_req = 0;
    checks++;
    if (led_ew !== 3'b001 || dut.ped_pending_q !== 1'b1) begin
      errors++; $display("FAIL ewy_setup ew=%b pend=%b want 001/1", led_ew, dut.ped_pending_q);
    end
    #3 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (dut_out() !== RST_OUT) begin errors++; $display("FAIL async_reset got=%h want=%h", dut_out(), RST_OUT); end
    checks++;
    if (dut.ped_pending_q !== 1'b0 || dut.time_cnt_q !== 7'd6) begin
      errors++; $display("FAIL async_regs pend=%b time=%0d want 0/6", dut.ped_pending_q, dut.time_cnt_q);
    end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 70; i++) begin
      run_cycle(0, 0);
      checks++;
      if (dut_out() !== exp_out()) begin errors++; $display("FAIL post_reset k=%0d got=%h want=%h", k2, dut_out(), exp_out()); end
      checks++;
      if (dut.time_cnt_q !== 7'(m_rem)) begin errors++; $display("FAIL post_reset_time k=%0d got=%0d want=%0d", k2, dut.time_cnt_q, m_rem); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    dur  = '{NSG, YT, ART, EWG, YT, ART};
    segc = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    rst_n = 0; night_mode = 0; ped_req = 0; night_mode2 = 0; ped_req2 = 0;
    test_reset();
    test_normal_cycle();
    test_ped_short();
    test_ped_at_ew_entry();
    test_night();
    test_display();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
